// File: rtl/anton_neopixel_frame_sequencer_if.sv
// Control-register and stream-controller signals seen by the NeoPixel frame sequencer.
// The master side drives the control bits and overflow flags; the slave side is the sequencer.
interface anton_neopixel_frame_sequencer_if;
    logic        reg_ctrl_init;
    logic        reg_ctrl_run;
    logic        reg_ctrl_loop;
    logic        stream_bit_of;
    logic        stream_pixel_of;
    logic        state;
    logic        busy;
    logic        frame_done;
    logic        run_clear;
    logic [15:0] frame_count;

    modport master (
        output reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, stream_bit_of, stream_pixel_of,
        input  state, busy, frame_done, run_clear, frame_count
    );

    modport slave (
        input  reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, stream_bit_of, stream_pixel_of,
        output state, busy, frame_done, run_clear, frame_count
    );
endinterface

// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame-level scheduler for the NeoPixel stream: transmit / latch timing, one-shot and
// loop modes, abort handling and frame counting. All outputs are registered.
module anton_neopixel_frame_sequencer #(
    parameter int RESET_CYCLES = 420
) (
    input  logic                            clk7mhz,
    input  logic                            rst,
    anton_neopixel_frame_sequencer_if.slave bus
);
    localparam int RST_BITS = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_BITS-1:0] LATCH_LOAD = RST_BITS'(RESET_CYCLES - 1);
    localparam logic STATE_TRANSMIT = 1'b1;
    localparam logic STATE_RESET    = 1'b0;

    typedef enum logic [1:0] {IDLE, TRANSMIT, LATCH} fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [RST_BITS-1:0] latch_cnt_q, latch_cnt_d;
    logic                abort_q, abort_d;
    logic                rearm_q, rearm_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                frame_done_q, frame_done_d;
    logic                run_clear_q, run_clear_d;
    logic                state_q;
    logic                busy_q;

    // Priority: init, then run falling, then frame end / loop decision.
    always_comb begin
        fsm_d         = fsm_q;
        latch_cnt_d   = latch_cnt_q;
        abort_d       = abort_q;
        rearm_d       = rearm_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        run_clear_d   = 1'b0;

        if (bus.reg_ctrl_init) begin
            fsm_d         = IDLE;
            latch_cnt_d   = '0;
            abort_d       = 1'b0;
            rearm_d       = 1'b0;
            frame_count_d = '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    // After a one-shot, run must be seen low before a new frame may start.
                    if (!bus.reg_ctrl_run) begin
                        rearm_d = 1'b0;
                    end else if (!rearm_q) begin
                        fsm_d = TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (!bus.reg_ctrl_run) begin
                        fsm_d       = LATCH;
                        latch_cnt_d = LATCH_LOAD;
                        abort_d     = 1'b1;
                        run_clear_d = 1'b1;
                    end else if (bus.stream_bit_of && bus.stream_pixel_of) begin
                        fsm_d       = LATCH;
                        latch_cnt_d = LATCH_LOAD;
                    end
                end
                LATCH: begin
                    if (latch_cnt_q != '0) begin
                        latch_cnt_d = latch_cnt_q - RST_BITS'(1);
                    end else begin
                        frame_done_d = 1'b1;
                        abort_d      = 1'b0;
                        if (!abort_q) begin
                            frame_count_d = frame_count_q + 16'd1;
                        end
                        if (bus.reg_ctrl_loop && bus.reg_ctrl_run && !abort_q) begin
                            fsm_d = TRANSMIT;
                        end else begin
                            fsm_d = IDLE;
                            if (!bus.reg_ctrl_loop && !abort_q) begin
                                run_clear_d = 1'b1;
                                rearm_d     = 1'b1;
                            end
                        end
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk7mhz or posedge rst) begin
        if (rst) begin
            fsm_q         <= IDLE;
            latch_cnt_q   <= '0;
            abort_q       <= 1'b0;
            rearm_q       <= 1'b0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            run_clear_q   <= 1'b0;
            state_q       <= STATE_RESET;
            busy_q        <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            latch_cnt_q   <= latch_cnt_d;
            abort_q       <= abort_d;
            rearm_q       <= rearm_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            run_clear_q   <= run_clear_d;
            state_q       <= (fsm_d == TRANSMIT) ? STATE_TRANSMIT : STATE_RESET;
            busy_q        <= (fsm_d != IDLE);
        end
    end

    assign bus.state       = state_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.run_clear   = run_clear_q;
    assign bus.frame_count = frame_count_q;
endmodule
